// File: rtl/div_nm_seq_if.sv
// Start/busy/done handshake bundle for the sequential N+M by M divider.
interface div_nm_seq_if #(
  parameter int N = 4,
  parameter int M = 5
);
  logic             start;
  logic [N+M-1:0]   Dividend;
  logic [M-1:0]     Divisor;
  logic             busy;
  logic             done;
  logic [N+M-1:0]   Q;
  logic [M-1:0]     R;
  logic             dbz;
  logic             ovf;

  modport master (
    output start, Dividend, Divisor,
    input  busy, done, Q, R, dbz, ovf
  );

  modport slave (
    input  start, Dividend, Divisor,
    output busy, done, Q, R, dbz, ovf
  );
endinterface

// File: rtl/div_nm_seq.sv
// Sequential restoring divider: W=N+M bit dividend by M bit divisor, one bit per clock.
// Define DIV_NM_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module div_nm_seq #(
  parameter int N = 4,
  parameter int M = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  div_nm_seq_if.slave  bus
);
  localparam int W  = N + M;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state;
  logic [M:0]      acc;
  logic [W-1:0]    quo;
  logic [M-1:0]    dvs;
  logic [CW-1:0]   cnt;
  logic            busy_r;
  logic            done_r;
  logic [W-1:0]    q_r;
  logic [M-1:0]    r_r;
  logic            dbz_r;
  logic            ovf_r;

  logic [W-1:0]    dend_mag;
  logic [M-1:0]    dvs_mag;
  logic [M+1:0]    shifted;
  logic [M+1:0]    diff;
  logic            keep;
  logic [W-1:0]    q_fix;
  logic [M-1:0]    r_fix;

`ifdef DIV_NM_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic ovf_case;

  // The most negative dividend has a magnitude that still fits W bits unsigned.
  assign dend_mag = bus.Dividend[W-1] ? -bus.Dividend : bus.Dividend;
  assign dvs_mag  = bus.Divisor[M-1]  ? -bus.Divisor  : bus.Divisor;
  assign q_fix    = neg_q ? -quo : quo;
  assign r_fix    = neg_r ? -acc[M-1:0] : acc[M-1:0];
`else
  assign dend_mag = bus.Dividend;
  assign dvs_mag  = bus.Divisor;
  assign q_fix    = quo;
  assign r_fix    = acc[M-1:0];
`endif

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign shifted = {acc, quo[W-1]};
  assign diff    = shifted - {2'b00, dvs};
  assign keep    = ~diff[M+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      q_r    <= '0;
      r_r    <= '0;
      dbz_r  <= 1'b0;
      ovf_r  <= 1'b0;
`ifdef DIV_NM_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ovf_case <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= '0;
            quo    <= dend_mag;
            dvs    <= dvs_mag;
            cnt    <= CW'(W - 1);
            busy_r <= 1'b1;
            state  <= CALC;
`ifdef DIV_NM_SIGNED_EN
            neg_q    <= bus.Dividend[W-1] ^ bus.Divisor[M-1];
            neg_r    <= bus.Dividend[W-1];
            ovf_case <= (bus.Dividend == {1'b1, {(W-1){1'b0}}}) && (bus.Divisor == '1);
`endif
          end
        end
        CALC: begin
          acc <= keep ? diff[M:0] : shifted[M:0];
          quo <= {quo[W-2:0], keep};
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          // A zero divisor overrides whatever the iteration produced.
          if (dvs == '0) begin
            q_r   <= '1;
            r_r   <= '0;
            dbz_r <= 1'b1;
            ovf_r <= 1'b0;
          end else begin
            q_r   <= q_fix;
            r_r   <= r_fix;
            dbz_r <= 1'b0;
`ifdef DIV_NM_SIGNED_EN
            ovf_r <= ovf_case;
`else
            ovf_r <= 1'b0;
`endif
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.Q    = q_r;
  assign bus.R    = r_r;
  assign bus.dbz  = dbz_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_div_nm_seq.sv
// Scoreboard bench for div_nm_seq: directed vectors push expected results, a monitor checks each done.
module tb_div_nm_seq;
  localparam int N = 4;
  localparam int M = 5;
  localparam int W = N + M;

  typedef struct {
    logic [W-1:0] q;
    logic [M-1:0] r;
    logic         dbz;
    logic         ovf;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   seen;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  div_nm_seq_if #(.N(N), .M(M)) bus ();

  div_nm_seq #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Results are checked here whenever done is seen, independent of the stimulus thread.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("result_q", 32'(bus.Q), 32'(mon_e.q));
        checkOutput("result_r", 32'(bus.R), 32'(mon_e.r));
        checkOutput("result_dbz", 32'(bus.dbz), 32'(mon_e.dbz));
        checkOutput("result_ovf", 32'(bus.ovf), 32'(mon_e.ovf));
        checkOutput("latency", 32'(cyc), 32'(mon_e.due));
        checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] dd, input logic [M-1:0] dv,
                               input logic [W-1:0] eq, input logic [M-1:0] er,
                               input logic ed, input logic eo);
    exp_t e;
    bus.start    = 1'b1;
    bus.Dividend = dd;
    bus.Divisor  = dv;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.Dividend = W'($urandom);
    bus.Divisor  = M'($urandom);
    e.q   = eq;
    e.r   = er;
    e.dbz = ed;
    e.ovf = eo;
    e.due = cyc + W + 1;
    sb.push_back(e);
    checkOutput("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  task automatic waitDone(input int exp_busy, output bit got);
    int n = 0;
    int busy_n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      if (bus.done === 1'b1) got = 1'b1;
      else begin
        n++;
        if (bus.busy === 1'b1) busy_n++;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout actual=0 expected=1 after %0d cycles", n);
    end else begin
      checkOutput("busy_cycles", 32'(busy_n), 32'(exp_busy));
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.Dividend = '0;
    bus.Divisor  = '0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_q", 32'(bus.Q), 32'd0);
    checkOutput("reset_r", 32'(bus.R), 32'd0);
    checkOutput("reset_dbz", 32'(bus.dbz), 32'd0);
    checkOutput("reset_ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef DIV_NM_SIGNED_EN
    $display("[TB] signed build");
    applyStimulus(9'h006, 5'h02, 9'h003, 5'h00, 1'b0, 1'b0); waitDone(W, seen);
    applyStimulus(9'h1F9, 5'h02, 9'h1FD, 5'h1F, 1'b0, 1'b0); waitDone(W, seen);
    applyStimulus(9'h1E7, 5'h1B, 9'h005, 5'h00, 1'b0, 1'b0); waitDone(W, seen);
    applyStimulus(9'h02D, 5'h00, 9'h1FF, 5'h00, 1'b1, 1'b0); waitDone(W, seen);
`else
    $display("[TB] unsigned build");
    applyStimulus(9'h006, 5'h02, 9'h003, 5'h00, 1'b0, 1'b0); waitDone(W, seen);
    applyStimulus(9'h1F9, 5'h02, 9'h0FC, 5'h01, 1'b0, 1'b0); waitDone(W, seen);
    applyStimulus(9'h1E7, 5'h1B, 9'h012, 5'h01, 1'b0, 1'b0); waitDone(W, seen);
    applyStimulus(9'h02D, 5'h00, 9'h1FF, 5'h00, 1'b1, 1'b0); waitDone(W, seen);
`endif

    // Outputs must hold between results.
    repeat (4) @(negedge clk);
    checkOutput("hold_q", 32'(bus.Q), 32'h1FF);
    checkOutput("hold_dbz", 32'(bus.dbz), 32'd1);
    checkOutput("hold_done", 32'(bus.done), 32'd0);

`ifdef DIV_NM_SIGNED_EN
    applyStimulus(9'h100, 5'h1F, 9'h100, 5'h00, 1'b0, 1'b1); waitDone(W, seen);
`else
    applyStimulus(9'h100, 5'h1F, 9'h008, 5'h08, 1'b0, 1'b0); waitDone(W, seen);
`endif

    // A start pulse during CALC must be ignored.
    @(negedge clk);
    applyStimulus(9'h064, 5'h07, 9'h00E, 5'h02, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    bus.start    = 1'b1;
    bus.Dividend = 9'h0FF;
    bus.Divisor  = 5'h01;
    @(negedge clk);
    bus.start    = 1'b0;
    waitDone(W - 4, seen);

    // Back-to-back: start is raised in the done cycle.
    repeat (2) @(negedge clk);
`ifdef DIV_NM_SIGNED_EN
    applyStimulus(9'h1FF, 5'h1F, 9'h001, 5'h00, 1'b0, 1'b0); waitDone(W, seen);
    applyStimulus(9'h0F0, 5'h1D, 9'h1B0, 5'h00, 1'b0, 1'b0); waitDone(W, seen);
`else
    applyStimulus(9'h1FF, 5'h1F, 9'h010, 5'h0F, 1'b0, 1'b0); waitDone(W, seen);
    applyStimulus(9'h0F0, 5'h1D, 9'h008, 5'h08, 1'b0, 1'b0); waitDone(W, seen);
`endif

    // Asynchronous reset in the middle of CALC aborts the operation.
    repeat (2) @(negedge clk);
    applyStimulus(9'h0AA, 5'h03, 9'h038, 5'h02, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_q", 32'(bus.Q), 32'd0);
    checkOutput("abort_r", 32'(bus.R), 32'd0);
    checkOutput("abort_dbz", 32'(bus.dbz), 32'd0);
    checkOutput("abort_ovf", 32'(bus.ovf), 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(9'h00F, 5'h03, 9'h005, 5'h00, 1'b0, 1'b0); waitDone(W, seen);

    // Any stray done from an ignored start would be flagged by the monitor here.
    repeat (15) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
